// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock through a registered borrow,
// then presents a sign-extended difference, borrow/negative flag and magnitude for one done cycle.
module four_bit_serial_subtractor #(
  parameter int N     = 4,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N-1:0]            a,
  input  logic [N-1:0]            b,
  output logic                    busy,
  output logic                    done,
  output logic signed [OUT_W-1:0] d,
  output logic                    bout,
  output logic                    neg,
  output logic [N-1:0]            mag
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     sa, sb;
  logic [N-1:0]     acc;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic             dbit;
  logic             br_nxt;
  logic [N-1:0]     diff_nxt;

  function automatic logic [N-1:0] abs_diff(input logic [N-1:0] diff, input logic is_neg);
    return is_neg ? (~diff + N'(1)) : diff;
  endfunction

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (state == S_RUN) && (cnt == CNT_W'(N - 1));
  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);

  // Full-subtractor cell on the LSBs; difference bits enter acc from the top so bit 0 lands last
  always_comb begin
    dbit     = sa[0] ^ sb[0] ^ br;
    br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    diff_nxt = {dbit, acc[N-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
      neg  <= 1'b0;
      mag  <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      acc <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == S_RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= diff_nxt;
      br  <= br_nxt;
      cnt <= cnt + CNT_W'(1);
      // Result registers only move on the final bit, so they hold through RUN
      if (last) begin
        d    <= {{(OUT_W - N){br_nxt}}, diff_nxt};
        bout <= br_nxt;
        neg  <= br_nxt;
        mag  <= abs_diff(diff_nxt, br_nxt);
      end
    end
  end

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Directed bench for four_bit_serial_subtractor: vector table plus start-in-RUN, mid-run reset
// and back-to-back sequences.
module tb_four_bit_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done, bout, neg;
  logic [7:0] d;
  logic [3:0] mag;

  int checks = 0;
  int errors = 0;

  four_bit_serial_subtractor #(.N(4), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bout(bout), .neg(neg), .mag(mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] d;
    logic       bout;
    logic [3:0] mag;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request from IDLE, waits (bounded) for done, reports busy cycles and output stability
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi,
                       output int busy_cnt, output logic stable);
    logic [7:0] d_hold;
    int         n;
    d_hold   = d;
    stable   = 1'b1;
    busy_cnt = 0;
    a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ai; b = ~bi;
    n = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (d !== d_hold) stable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int   bc;
    logic st;
    int   done_cnt;
    logic [7:0] d_cap;
    logic [7:0] prev_d;
    logic [3:0] opa[4];
    logic [3:0] opb[4];
    logic [7:0] expd[4];

    vecs[0] = '{4'd9,  4'd3,  8'h06, 1'b0, 4'd6};
    vecs[1] = '{4'd3,  4'd9,  8'hFA, 1'b1, 4'd6};
    vecs[2] = '{4'd0,  4'd15, 8'hF1, 1'b1, 4'd15};
    vecs[3] = '{4'd15, 4'd0,  8'h0F, 1'b0, 4'd15};
    vecs[4] = '{4'd15, 4'd15, 8'h00, 1'b0, 4'd0};
    vecs[5] = '{4'd8,  4'd7,  8'h01, 1'b0, 4'd1};
    vecs[6] = '{4'd7,  4'd8,  8'hFF, 1'b1, 4'd1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset d",    d,    0);
    check("reset bout", bout, 0);
    check("reset neg",  neg,  0);
    check("reset mag",  mag,  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, bc, st);
      check($sformatf("v%0d busy cycles", i), bc, 4);
      check($sformatf("v%0d done", i), done, 1);
      check($sformatf("v%0d busy at done", i), busy, 0);
      check($sformatf("v%0d d", i), d, vecs[i].d);
      check($sformatf("v%0d bout", i), bout, vecs[i].bout);
      check($sformatf("v%0d neg", i), neg, vecs[i].bout);
      check($sformatf("v%0d mag", i), mag, vecs[i].mag);
      check($sformatf("v%0d hold in run", i), st, 1);
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse end", i), done, 0);
    end

    // start pulsed during RUN must be ignored
    a = 4'd7; b = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd0; b = 4'd0;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0; d_cap = 8'h00;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        done_cnt++;
        d_cap = d;
      end
      @(posedge clk); #1;
    end
    check("ignore start done count", done_cnt, 1);
    check("ignore start d", d_cap, 8'h05);
    check("ignore start d after", d, 8'h05);

    // reset asserted mid-RUN aborts the operation
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort d",    d,    0);
    check("abort bout", bout, 0);
    check("abort neg",  neg,  0);
    check("abort mag",  mag,  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    check("abort no done", done_cnt, 0);
    do_op(4'd5, 4'd12, bc, st);
    check("post abort done", done, 1);
    check("post abort d", d, 8'hF9);
    check("post abort bout", bout, 1);
    check("post abort mag", mag, 4'd7);
    @(posedge clk); #1;

    // back-to-back with start held high
    opa[0] = 4'd6; opb[0] = 4'd1; expd[0] = 8'h05;
    opa[1] = 4'd1; opb[1] = 4'd6; expd[1] = 8'hFB;
    opa[2] = 4'd6; opb[2] = 4'd1; expd[2] = 8'h05;
    opa[3] = 4'd1; opb[3] = 4'd6; expd[3] = 8'hFB;
    prev_d = d;
    a = opa[0]; b = opb[0]; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n;
      @(posedge clk); #1;
      a = ~opa[k]; b = ~opb[k];
      st = 1'b1;
      n = 1;
      while (!done && n < 20) begin
        if (d !== prev_d || !busy) st = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("b2b%0d period", k), n, 5);
      check($sformatf("b2b%0d d", k), d, expd[k]);
      check($sformatf("b2b%0d hold", k), st, 1);
      prev_d = d;
      if (k < 3) begin
        a = opa[k+1]; b = opb[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("b2b end done", done, 0);
    check("b2b end busy", busy, 0);
    check("b2b end d", d, 8'hFB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
